// File: rtl/shm_client_port_if.sv
// rtl/shm_client_port_if.sv - request, response and SHM-side signals of one processor slot
interface shm_client_port_if #(
    parameter int SIZE      = 16,
    parameter int WORD_SIZE = 16,
    parameter int PAGE_SIZE = 4
);
    localparam int PAGES_COUNT = SIZE - PAGE_SIZE;

    logic                   req_valid;
    logic                   req_ready;
    logic [1:0]             req_action;
    logic [PAGES_COUNT-1:0] req_ptr;
    logic [SIZE-1:0]        req_shift;
    logic [WORD_SIZE-1:0]   req_data;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             rsp_action;
    logic [WORD_SIZE-1:0]   rsp_data;
    logic [PAGES_COUNT-1:0] rsp_ptr;
    logic                   rsp_timeout;

    logic                   shm_trigger;
    logic                   shm_ack;
    logic [1:0]             shm_action;
    logic [PAGES_COUNT-1:0] shm_ptr;
    logic [SIZE-1:0]        shm_shift;
    logic [WORD_SIZE-1:0]   shm_data_in;
    logic [WORD_SIZE-1:0]   shm_data_out;
    logic [PAGES_COUNT-1:0] shm_ptr_out;

    logic                   busy;

    modport slave (
        input  req_valid, req_action, req_ptr, req_shift, req_data,
        output req_ready,
        output rsp_valid, rsp_action, rsp_data, rsp_ptr, rsp_timeout,
        input  rsp_ready,
        output shm_trigger, shm_action, shm_ptr, shm_shift, shm_data_in,
        input  shm_ack, shm_data_out, shm_ptr_out,
        output busy
    );

    modport master (
        output req_valid, req_action, req_ptr, req_shift, req_data,
        input  req_ready,
        input  rsp_valid, rsp_action, rsp_data, rsp_ptr, rsp_timeout,
        output rsp_ready,
        input  shm_trigger, shm_action, shm_ptr, shm_shift, shm_data_in,
        output shm_ack, shm_data_out, shm_ptr_out,
        input  busy
    );
endinterface

// File: rtl/shm_client_port.sv
// rtl/shm_client_port.sv - per-processor request FIFO and toggle handshake bridge to SHM
module shm_client_port #(
    parameter int SIZE       = 16,
    parameter int WORD_SIZE  = 16,
    parameter int PAGE_SIZE  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic             clock,
    input  logic             reset_n,
    shm_client_port_if.slave port
);
    localparam int PAGES_COUNT = SIZE - PAGE_SIZE;
    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int CW          = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t state, next_state;

    logic [1:0]             fifo_action [FIFO_DEPTH];
    logic [PAGES_COUNT-1:0] fifo_ptr    [FIFO_DEPTH];
    logic [SIZE-1:0]        fifo_shift  [FIFO_DEPTH];
    logic [WORD_SIZE-1:0]   fifo_data   [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count;
    logic                   full, empty, push;

    logic                   ack_seen, ack_diff;
    logic [CW-1:0]          tmo_cnt;
    logic                   issue, ack_hit, tmo_hit;

    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push     = port.req_valid && !full;
    assign ack_diff = (port.shm_ack != ack_seen);

    assign port.req_ready = !full;
    assign port.busy      = !empty || (state != S_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        issue      = 1'b0;
        ack_hit    = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            S_IDLE: begin
                // A pending (late) ack blocks issue so it cannot be matched to the new request.
                if (!empty && !ack_diff) begin
                    issue      = 1'b1;
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ack_diff) begin
                    ack_hit    = 1'b1;
                    next_state = S_RESP;
                end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                    tmo_hit    = 1'b1;
                    next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (port.rsp_valid && port.rsp_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_action[wr_ptr] <= port.req_action;
            fifo_ptr[wr_ptr]    <= port.req_ptr;
            fifo_shift[wr_ptr]  <= port.req_shift;
            fifo_data[wr_ptr]   <= port.req_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + AW'(1);
            if (issue) rd_ptr <= rd_ptr + AW'(1);
            case ({push, issue})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Every ack edge is consumed in whatever state it shows up: WAIT matches it,
    // IDLE/RESP absorb it as a late ack, so ack_seen simply follows shm_ack.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ack_seen         <= 1'b0;
            tmo_cnt          <= '0;
            port.shm_trigger <= 1'b0;
            port.shm_action  <= '0;
            port.shm_ptr     <= '0;
            port.shm_shift   <= '0;
            port.shm_data_in <= '0;
            port.rsp_valid   <= 1'b0;
            port.rsp_timeout <= 1'b0;
            port.rsp_action  <= '0;
            port.rsp_data    <= '0;
            port.rsp_ptr     <= '0;
        end else begin
            ack_seen <= port.shm_ack;
            if (issue) begin
                port.shm_action  <= fifo_action[rd_ptr];
                port.shm_ptr     <= fifo_ptr[rd_ptr];
                port.shm_shift   <= fifo_shift[rd_ptr];
                port.shm_data_in <= fifo_data[rd_ptr];
                port.shm_trigger <= ~port.shm_trigger;
                tmo_cnt          <= '0;
            end else if (state == S_WAIT) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end
            if (ack_hit) begin
                port.rsp_valid   <= 1'b1;
                port.rsp_timeout <= 1'b0;
                port.rsp_action  <= port.shm_action;
                port.rsp_data    <= port.shm_data_out;
                port.rsp_ptr     <= port.shm_ptr_out;
            end else if (tmo_hit) begin
                port.rsp_valid   <= 1'b1;
                port.rsp_timeout <= 1'b1;
                port.rsp_action  <= port.shm_action;
                port.rsp_data    <= '0;
                port.rsp_ptr     <= '0;
            end else if (state == S_RESP && port.rsp_ready) begin
                port.rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_shm_client_port.sv
// tb/tb_shm_client_port.sv - directed self-checking bench for shm_client_port
module tb_shm_client_port;
    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;
    logic exp_trig = 1'b0;

    shm_client_port_if #(.SIZE(16), .WORD_SIZE(16), .PAGE_SIZE(4)) bus ();

    shm_client_port #(
        .SIZE(16), .WORD_SIZE(16), .PAGE_SIZE(4), .FIFO_DEPTH(4), .TIMEOUT(8)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .port    (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [1:0] a, input logic [11:0] p, input logic [15:0] s, input logic [15:0] d);
        bus.req_valid  = 1'b1;
        bus.req_action = a;
        bus.req_ptr    = p;
        bus.req_shift  = s;
        bus.req_data   = d;
        tick();
        bus.req_valid  = 1'b0;
    endtask

    task automatic serve(input logic [15:0] d, input logic [11:0] p);
        bus.shm_data_out = d;
        bus.shm_ptr_out  = p;
        bus.shm_ack      = ~bus.shm_ack;
        tick();
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got %0h exp 1", bus.req_ready); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %0h exp 0", bus.busy); end
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %0h exp 0", bus.rsp_valid); end
        checks++; if (bus.shm_trigger !== 1'b0) begin failures++; $display("FAIL reset_trigger got %0h exp 0", bus.shm_trigger); end
        checks++; if ({bus.rsp_timeout, bus.rsp_action, bus.rsp_data, bus.rsp_ptr} !== '0) begin failures++; $display("FAIL reset_rsp_fields got %0h exp 0", {bus.rsp_timeout, bus.rsp_action, bus.rsp_data, bus.rsp_ptr}); end
        checks++; if ({bus.shm_action, bus.shm_ptr, bus.shm_shift, bus.shm_data_in} !== '0) begin failures++; $display("FAIL reset_shm_fields got %0h exp 0", {bus.shm_action, bus.shm_ptr, bus.shm_shift, bus.shm_data_in}); end
    endtask

    task automatic test_single_read();
        push(2'd0, 12'd5, 16'h0012, 16'h0000);
        checks++; if (bus.shm_trigger !== exp_trig) begin failures++; $display("FAIL read_trig_before got %0h exp %0h", bus.shm_trigger, exp_trig); end
        tick();
        exp_trig = ~exp_trig;
        checks++; if (bus.shm_trigger !== exp_trig) begin failures++; $display("FAIL read_trig_issue got %0h exp %0h", bus.shm_trigger, exp_trig); end
        checks++; if (bus.shm_ptr !== 12'd5 || bus.shm_shift !== 16'h0012 || bus.shm_action !== 2'd0) begin failures++; $display("FAIL read_shm_fields got %0h/%0h/%0h exp 5/12/0", bus.shm_ptr, bus.shm_shift, bus.shm_action); end
        tick();
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL read_rsp_early got %0h exp 0", bus.rsp_valid); end
        serve(16'hBEEF, 12'h000);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'hBEEF || bus.rsp_timeout !== 1'b0 || bus.rsp_action !== 2'd0) begin failures++; $display("FAIL read_rsp got v=%0h d=%0h t=%0h a=%0h exp 1/beef/0/0", bus.rsp_valid, bus.rsp_data, bus.rsp_timeout, bus.rsp_action); end
        consume();
        checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL read_done got v=%0h busy=%0h exp 0/0", bus.rsp_valid, bus.busy); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            bus.req_valid  = 1'b1;
            bus.req_action = 2'd1;
            bus.req_ptr    = 12'(i);
            bus.req_shift  = 16'(i);
            bus.req_data   = 16'hA000 + 16'(i);
            tick();
        end
        bus.req_valid = 1'b0;
        exp_trig = ~exp_trig;
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL b2b_full got %0h exp 0", bus.req_ready); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.shm_data_in !== 16'hA000 + 16'(i) || bus.shm_trigger !== exp_trig) begin failures++; $display("FAIL b2b_issue%0d got d=%0h t=%0h exp %0h/%0h", i, bus.shm_data_in, bus.shm_trigger, 16'hA000 + 16'(i), exp_trig); end
            serve(16'h0100 + 16'(i), 12'h000);
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_action !== 2'd1 || bus.rsp_data !== 16'h0100 + 16'(i)) begin failures++; $display("FAIL b2b_rsp%0d got v=%0h a=%0h d=%0h exp 1/1/%0h", i, bus.rsp_valid, bus.rsp_action, bus.rsp_data, 16'h0100 + 16'(i)); end
            consume();
            tick();
            if (i < 4) exp_trig = ~exp_trig;
        end
        checks++; if (bus.busy !== 1'b0 || bus.shm_trigger !== exp_trig) begin failures++; $display("FAIL b2b_drained got busy=%0h t=%0h exp 0/%0h", bus.busy, bus.shm_trigger, exp_trig); end
    endtask

    task automatic test_alloc_hold();
        push(2'd2, 12'd3, 16'h0000, 16'h0000);
        tick();
        exp_trig = ~exp_trig;
        checks++; if (bus.shm_action !== 2'd2 || bus.shm_trigger !== exp_trig) begin failures++; $display("FAIL alloc_issue got a=%0h t=%0h exp 2/%0h", bus.shm_action, bus.shm_trigger, exp_trig); end
        push(2'd0, 12'd9, 16'h0004, 16'h0000);
        serve(16'h0000, 12'h07A);
        for (int j = 0; j < 10; j++) begin
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_ptr !== 12'h07A || bus.rsp_action !== 2'd2 || bus.shm_trigger !== exp_trig) begin failures++; $display("FAIL alloc_hold%0d got v=%0h p=%0h a=%0h t=%0h exp 1/7a/2/%0h", j, bus.rsp_valid, bus.rsp_ptr, bus.rsp_action, bus.shm_trigger, exp_trig); end
            tick();
        end
        consume();
        checks++; if (bus.rsp_valid !== 1'b0 || bus.shm_trigger !== exp_trig) begin failures++; $display("FAIL alloc_release got v=%0h t=%0h exp 0/%0h", bus.rsp_valid, bus.shm_trigger, exp_trig); end
        tick();
        exp_trig = ~exp_trig;
        checks++; if (bus.shm_trigger !== exp_trig || bus.shm_ptr !== 12'd9) begin failures++; $display("FAIL alloc_next_issue got t=%0h p=%0h exp %0h/9", bus.shm_trigger, bus.shm_ptr, exp_trig); end
        serve(16'h5555, 12'h000);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h5555) begin failures++; $display("FAIL alloc_next_rsp got v=%0h d=%0h exp 1/5555", bus.rsp_valid, bus.rsp_data); end
        consume();
    endtask

    task automatic test_timeout();
        bus.shm_data_out = 16'h1234;
        bus.shm_ptr_out  = 12'h0AB;
        push(2'd0, 12'd1, 16'h0000, 16'h0000);
        tick();
        exp_trig = ~exp_trig;
        checks++; if (bus.shm_trigger !== exp_trig) begin failures++; $display("FAIL tmo_issue got %0h exp %0h", bus.shm_trigger, exp_trig); end
        push(2'd1, 12'd2, 16'h0004, 16'hCAFE);
        for (int j = 2; j < 8; j++) tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL tmo_early got %0h exp 0", bus.rsp_valid); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_timeout !== 1'b1 || bus.rsp_data !== 16'h0000 || bus.rsp_ptr !== 12'h000) begin failures++; $display("FAIL tmo_rsp got v=%0h t=%0h d=%0h p=%0h exp 1/1/0/0", bus.rsp_valid, bus.rsp_timeout, bus.rsp_data, bus.rsp_ptr); end
        serve(16'h9999, 12'h000);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_timeout !== 1'b1 || bus.rsp_data !== 16'h0000 || bus.shm_trigger !== exp_trig) begin failures++; $display("FAIL tmo_late_ack got v=%0h t=%0h d=%0h tr=%0h exp 1/1/0/%0h", bus.rsp_valid, bus.rsp_timeout, bus.rsp_data, bus.shm_trigger, exp_trig); end
        consume();
        checks++; if (bus.rsp_valid !== 1'b0 || bus.shm_trigger !== exp_trig) begin failures++; $display("FAIL tmo_release got v=%0h t=%0h exp 0/%0h", bus.rsp_valid, bus.shm_trigger, exp_trig); end
        tick();
        exp_trig = ~exp_trig;
        checks++; if (bus.shm_trigger !== exp_trig || bus.shm_data_in !== 16'hCAFE) begin failures++; $display("FAIL tmo_next_issue got t=%0h d=%0h exp %0h/cafe", bus.shm_trigger, bus.shm_data_in, exp_trig); end
        serve(16'h4321, 12'h000);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_timeout !== 1'b0 || bus.rsp_data !== 16'h4321 || bus.rsp_action !== 2'd1) begin failures++; $display("FAIL tmo_next_rsp got v=%0h t=%0h d=%0h a=%0h exp 1/0/4321/1", bus.rsp_valid, bus.rsp_timeout, bus.rsp_data, bus.rsp_action); end
        consume();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            bus.req_valid  = 1'b1;
            bus.req_action = 2'd1;
            bus.req_ptr    = 12'h0FF;
            bus.req_shift  = 16'h00FF;
            bus.req_data   = 16'h7700 + 16'(i);
            tick();
        end
        bus.req_valid = 1'b0;
        exp_trig = ~exp_trig;
        checks++; if (bus.shm_trigger !== exp_trig || bus.busy !== 1'b1) begin failures++; $display("FAIL rstmid_pre got t=%0h b=%0h exp %0h/1", bus.shm_trigger, bus.busy, exp_trig); end
        #2 reset_n = 1'b0;
        bus.shm_ack = 1'b0;
        #1;
        checks++; if (bus.shm_trigger !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl got t=%0h r=%0h b=%0h v=%0h exp 0/1/0/0", bus.shm_trigger, bus.req_ready, bus.busy, bus.rsp_valid); end
        checks++; if ({bus.shm_ptr, bus.shm_shift, bus.shm_data_in, bus.shm_action, bus.rsp_data, bus.rsp_action} !== '0) begin failures++; $display("FAIL rstmid_fields got %0h exp 0", {bus.shm_ptr, bus.shm_shift, bus.shm_data_in, bus.shm_action, bus.rsp_data, bus.rsp_action}); end
        #2 reset_n = 1'b1;
        exp_trig = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            checks++; if (bus.shm_trigger !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle%0d got t=%0h b=%0h exp 0/0", j, bus.shm_trigger, bus.busy); end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_q [5];
        exp_q = '{16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005};
        for (int i = 0; i < 4; i++) begin
            bus.req_valid  = 1'b1;
            bus.req_action = 2'd3;
            bus.req_ptr    = 12'(i);
            bus.req_shift  = 16'h0000;
            bus.req_data   = 16'h1000 + 16'(i);
            tick();
        end
        bus.req_valid = 1'b0;
        exp_trig = ~exp_trig;
        serve(16'h0000, 12'h000);
        consume();
        bus.req_valid = 1'b1;
        bus.req_data  = 16'h1004;
        tick();
        bus.req_valid = 1'b0;
        exp_trig = ~exp_trig;
        checks++; if (bus.shm_trigger !== exp_trig || bus.shm_data_in !== 16'h1001 || bus.req_ready !== 1'b1) begin failures++; $display("FAIL wrap_pushpop got t=%0h d=%0h r=%0h exp %0h/1001/1", bus.shm_trigger, bus.shm_data_in, bus.req_ready, exp_trig); end
        push(2'd3, 12'd5, 16'h0000, 16'h1005);
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL wrap_full got %0h exp 0", bus.req_ready); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.shm_data_in !== exp_q[i] || bus.shm_trigger !== exp_trig) begin failures++; $display("FAIL wrap_issue%0d got d=%0h t=%0h exp %0h/%0h", i, bus.shm_data_in, bus.shm_trigger, exp_q[i], exp_trig); end
            serve(16'h2000 + 16'(i), 12'h000);
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_action !== 2'd3 || bus.rsp_data !== 16'h2000 + 16'(i)) begin failures++; $display("FAIL wrap_rsp%0d got v=%0h a=%0h d=%0h exp 1/3/%0h", i, bus.rsp_valid, bus.rsp_action, bus.rsp_data, 16'h2000 + 16'(i)); end
            consume();
            tick();
            if (i < 4) exp_trig = ~exp_trig;
        end
        checks++; if (bus.busy !== 1'b0 || bus.shm_trigger !== exp_trig) begin failures++; $display("FAIL wrap_drained got b=%0h t=%0h exp 0/%0h", bus.busy, bus.shm_trigger, exp_trig); end
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_action   = 2'd0;
        bus.req_ptr      = '0;
        bus.req_shift    = '0;
        bus.req_data     = '0;
        bus.rsp_ready    = 1'b0;
        bus.shm_ack      = 1'b0;
        bus.shm_data_out = '0;
        bus.shm_ptr_out  = '0;
        repeat (3) @(posedge clock);
        #3 reset_n = 1'b1;
        tick();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_alloc_hold();
        test_timeout();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shm_client_port.md
# shm_client_port

Per-processor request bridge that sits directly upstream of the shared-memory controller (SHM), one instance per processor slot. It accepts READ/WRITE/ALLOC/FREE requests on a valid/ready interface and buffers them in a small FIFO. It issues them one at a time to SHM over the toggle-based trigger/ack handshake. It returns each result (data, page pointer, timeout flag) on a valid/ready response interface.

## Interface
Parameters:
- SIZE, 16, address width; shift width
- WORD_SIZE, 16, data word width
- PAGE_SIZE, 4, page exponent; PAGES_COUNT = SIZE - PAGE_SIZE (12), page pointer width
- FIFO_DEPTH, 4, request FIFO entries (power of two, ≥2)
- TIMEOUT, 255, max cycles waiting for ack (≥1); counter width $clog2(TIMEOUT+1)

Ports:
- clock  in  1  single clock; all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept (= not full)
- req_action  in  2  0 READ, 1 WRITE, 2 ALLOC, 3 FREE
- req_ptr  in  PAGES_COUNT  page pointer
- req_shift  in  SIZE  byte offset from ptr
- req_data  in  WORD_SIZE  write data
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer takes response
- rsp_action  out  2  action of completed request
- rsp_data  out  WORD_SIZE  SHM data_out captured at ack
- rsp_ptr  out  PAGES_COUNT  SHM ptr_out captured at ack
- rsp_timeout  out  1  request got no ack within TIMEOUT
- shm_trigger  out  1  toggles once per issued request
- shm_ack  in  1  SHM toggles once per served request
- shm_action / shm_ptr / shm_shift / shm_data_in  out  2 / PAGES_COUNT / SIZE / WORD_SIZE  registered request fields, stable from issue until next issue
- shm_data_out / shm_ptr_out  in  WORD_SIZE / PAGES_COUNT  SHM results
- busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- FIFO: push on req_valid & req_ready. Pop only on issue. req_ready = !full; when full, req_ready stays 0 even in a pop cycle. Push and pop in the same cycle are allowed when not full; count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- ack_seen: internal register tracking the last observed shm_ack level. SHM must present shm_ack = 0 out of reset.
- FSM states:
  - IDLE → WAIT when FIFO non-empty and shm_ack == ack_seen. Pop the head; load shm_* registers; invert shm_trigger; clear the timeout counter.
  - WAIT, when shm_ack != ack_seen: set ack_seen <= shm_ack; capture rsp_data, rsp_ptr, and rsp_action; rsp_timeout <= 0; rsp_valid <= 1; go to RESP.
  - WAIT, when the counter reaches TIMEOUT-1 with no ack: rsp_valid <= 1; rsp_timeout <= 1; rsp_data and rsp_ptr <= 0; go to RESP. ack_seen is not updated.
  - WAIT, otherwise: counter increments.
  - RESP → IDLE on rsp_valid & rsp_ready. rsp_valid drops at that edge.
- Late ack: an shm_ack != ack_seen seen in IDLE or RESP (only possible after a timeout) is absorbed. ack_seen <= shm_ack; no response is produced. IDLE will not issue while ack is pending, so a timed-out request is never aliased onto the next one.
- rsp_data is meaningful for READ, rsp_ptr for ALLOC. Both are captured verbatim for every action.
- All outputs are registered except req_ready and busy, which are combinational from registers.

## Timing
- Reset values: shm_trigger 0, ack_seen 0, rsp_valid 0, rsp_timeout 0, rsp_action/rsp_data/rsp_ptr 0, shm_action/shm_ptr/shm_shift/shm_data_in 0, FIFO empty, req_ready 1, busy 0, state IDLE.
- Reset asserted mid-operation clears everything immediately. The in-flight request and buffered requests are dropped. The SHM side must be reset together with this block.
- Latency:
  - Request pushed at edge E0 is issued at E1.
  - If SHM toggles ack so it is sampled at edge Ek (k ≥ 2), rsp_valid is high from Ek.
  - Minimum request-to-response is 2 edges.
  - Timeout: rsp_valid rises TIMEOUT edges after issue.
- Throughput: one request per (issue + ack wait + response handshake + 1 IDLE cycle); there is no issue in the RESP→IDLE cycle.
- shm_* fields never change while in WAIT.

## Test plan
- Single READ with ptr=5, shift=0x12 → shm_trigger toggles 0→1 one edge after push. SHM asserts ack=1 with data_out=0xBEEF three cycles later → rsp_valid=1, rsp_data=0xBEEF, rsp_timeout=0. rsp_ready=1 → IDLE, busy=0.
- Push 5 WRITEs back-to-back with SHM stalled → the first issues immediately, 4 sit in the FIFO. req_ready=0 on the 6th cycle. Ack each → the responses come out in push order with matching rsp_action.
- ALLOC with ptr_out=0x07A at ack, rsp_ready held low 10 cycles → rsp_valid and rsp_ptr=0x07A stay stable. No new trigger toggle until 1 cycle after rsp_ready.
- TIMEOUT=8, no ack → rsp_timeout=1 and rsp_data=0 at issue+8. Then the late ack toggle arrives during RESP → no second response. The next queued request issues only after the absorption; its ack is matched normally.
- reset_n low in WAIT with 3 queued requests → all outputs take reset values asynchronously, req_ready=1, and no trigger toggles after release until a new push.
- Simultaneous push and pop with FIFO at 3/4 → count stays 3, no entry is lost or duplicated across pointer wrap.
